ahb3lite_sram_param: RTL and testbench
======================================

# ahb3lite_sram_param

Parametrised AHB3-Lite single-port SRAM slave. It is the next generation of the fixed-width ahb3lite_sram1rw. It generalises data width and depth and adds programmable wait states, the two-cycle ERROR response for illegal transfers, and same-address read-after-write coherency. It sits on the AHB3-Lite bus behind the decoder/mux, and the existing AHB slave bench drives it.

## Interface

Parameters:

- DATA_WIDTH, 32: bus data width in bits; legal values 32 or 64.
- MEM_DEPTH, 256: number of DATA_WIDTH-wide words; power of two.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted in every OKAY data phase; range 0..3.

Ports (clock and reset first):

- HCLK, in, 1: single clock; all logic is rising-edge.
- HRESET, in, 1: reset; synchronous, active-high.
- HSEL, in, 1: slave select.
- HADDR, in, 32: byte address.
- HWRITE, in, 1: 1 = write, 0 = read.
- HSIZE, in, 3: transfer size, 2^HSIZE bytes.
- HBURST, in, 3: burst type; accepted and ignored, since each beat is handled independently.
- HPROT, in, 4: protection; accepted and ignored.
- HTRANS, in, 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWDATA, in, DATA_WIDTH: write data, sampled in the data phase.
- HREADY, in, 1: bus ready; high marks the end of the previous data phase.
- HRDATA, out, DATA_WIDTH: read data.
- HREADYOUT, out, 1: slave ready.
- HRESP, out, 1: 0 = OKAY, 1 = ERROR.

## Operation

- **Transfer acceptance.** A transfer is accepted when HSEL & HREADY & HTRANS[1] are all high at a rising edge. On acceptance the block registers HADDR, HWRITE and HSIZE for the data phase.
- **IDLE/BUSY or unselected.** No data phase follows. Outputs stay HREADYOUT=1 and HRESP=0.
- **Illegal transfer.** A transfer is illegal if any of these holds:
  - HADDR ≥ MEM_DEPTH·DATA_WIDTH/8;
  - HSIZE > log2(DATA_WIDTH/8);
  - the address is misaligned for HSIZE.
- **Illegal transfer response.** Two cycles, with no wait states and no memory update:
  - cycle 1: HREADYOUT=0, HRESP=1;
  - cycle 2: HREADYOUT=1, HRESP=1.
- **Legal transfer response.** WAIT_STATES cycles with HREADYOUT=0 and HRESP=0, then one final cycle with HREADYOUT=1 and HRESP=0.
- **Write.** The write commits at the rising edge that ends the final data-phase cycle. Byte lanes are little-endian, selected by HADDR[log2(DATA_WIDTH/8)-1:0] and HSIZE. Unselected lanes are unchanged.
- **Read.** The read returns the full word at HADDR's word index, valid during the final data-phase cycle. HRDATA is 0 in every other cycle.
- **State machine.**
  - IDLE → WAIT when a legal transfer is accepted and WAIT_STATES>0.
  - IDLE → DATA when a legal transfer is accepted and WAIT_STATES=0.
  - WAIT → DATA when the wait counter reaches WAIT_STATES.
  - DATA → IDLE, or directly to WAIT/DATA/ERR1 if a new transfer is accepted in the same cycle (pipelined).
  - IDLE/DATA → ERR1 on an illegal transfer; ERR1 → ERR2; ERR2 → IDLE, or to the next transfer's state.
- **Pipelining.** A new address phase is accepted only when HREADY=1, i.e. in DATA, ERR2 or IDLE.
- **Memory.** Register array of MEM_DEPTH × DATA_WIDTH, with no reset of its contents.

## Timing

- **Reset values.** HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, wait counter=0.
- **Latency with WAIT_STATES=0.** The data phase is the cycle after the address phase, so throughput is one transfer per cycle.
- **Latency with WAIT_STATES=N.** Each data phase lasts N+1 cycles.
- **Read-after-write.** A back-to-back write then read of the same word returns the newly written data: the write commits at the edge that starts the read data phase.
- **Write-after-write.** Back-to-back writes to the same word merge lanes in order.
- **Reset mid-transfer.** HRESET high in any state returns to IDLE at the next edge. A pending write is not committed, and an in-progress ERROR response is abandoned.
- **Address decode.** Address bits at or above log2(MEM_DEPTH·DATA_WIDTH/8) make the transfer illegal; they never alias into the array.
- **HREADY=0 during a data phase.** This can only come from another slave, because this slave's own HREADYOUT is fed back through the mux. The block holds state and does not accept a new address.

## Test plan

All scenarios use DATA_WIDTH=32 and MEM_DEPTH=256 unless stated.

1. **Reset then idle.** With WAIT_STATES=0: HRESET for 2 cycles, then HTRANS=IDLE for 5 cycles → HREADYOUT=1, HRESP=0, HRDATA=0 throughout.
2. **Pipelined word write and read.** With WAIT_STATES=0: NONSEQ word write 0xDEADBEEF to 0x10, immediately followed by NONSEQ word read of 0x10 → the read data phase has HRDATA=0xDEADBEEF and HREADYOUT=1, one cycle after the write data phase.
3. **Byte and halfword lanes.** Write word 0 to 0x20, byte 0xAA to 0x21, halfword 0x1234 to 0x22, then read 0x20 → HRDATA=0x1234AA00.
4. **Wait states.** With WAIT_STATES=2: word read of 0x04 → HREADYOUT low for exactly 2 cycles, then high for 1 cycle with valid data; HRESP=0 throughout.
5. **Errors.**
   - Write to 0x400 (out of range) → HREADYOUT 0 then 1 with HRESP=1 for both cycles; a later read of 0x000 shows the word unchanged.
   - Same two-cycle ERROR response for a word access at 0x02 (misaligned) and for HSIZE=3.
6. **Reset mid-transfer and 64-bit width.**
   - With WAIT_STATES=3: assert HRESET in the second wait cycle of a write of 0x55 to 0x08 → the next cycle shows HREADYOUT=1, and a read of 0x08 returns the prior value.
   - With DATA_WIDTH=64: a doubleword write then read of 0x0123456789ABCDEF returns the same value.

Source files
------------

// File: rtl/ahb3lite_sram_param_if.sv
// AHB3-Lite bus bundle between the master/decoder side and the SRAM slave.
// HREADY is driven by the bus mux, so it belongs to the master side here.
interface ahb3lite_sram_param_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [31:0]           HADDR;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT,
        output HTRANS, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT,
        input  HTRANS, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb3lite_sram_param.sv
// Parametrised AHB3-Lite single-port SRAM slave with wait states,
// two-cycle ERROR response and same-word read-after-write coherency.
module ahb3lite_sram_param #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input logic                  HCLK,
    input logic                  HRESET,
    ahb3lite_sram_param_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int AW = $clog2(MEM_DEPTH * NB);
    localparam int WW = $clog2(MEM_DEPTH);
    localparam logic [1:0] WS = 2'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2
    } state_t;

    state_t state, state_nx;
    logic [1:0] wcnt, wcnt_nx;

    logic [AW-1:0] addr_q;
    logic          wr_q;
    logic [2:0]    size_q;
    logic [WW-1:0] word_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic       open_st, accept, legal;
    logic       in_range, size_ok, aligned;
    logic [7:0] size_mask;
    logic       commit;
    logic [NB-1:0] be;
    logic       unused_ok;

    assign unused_ok = ^{bus.HBURST, bus.HPROT};

    assign open_st = (state == S_IDLE) || (state == S_DATA) ||
                     (state == S_ERR2);
    assign accept  = open_st && bus.HSEL && bus.HREADY && bus.HTRANS[1];

    // Upper address bits must be zero: they never alias into the array.
    assign size_mask = (8'd1 << bus.HSIZE) - 8'd1;
    assign in_range  = (bus.HADDR >> AW) == 32'd0;
    assign size_ok   = bus.HSIZE <= 3'(LB);
    assign aligned   = (bus.HADDR[7:0] & size_mask) == 8'd0;
    assign legal     = in_range && size_ok && aligned;

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        unique case (state)
            S_WAIT: begin
                if (wcnt == WS) begin
                    state_nx = S_DATA;
                    wcnt_nx  = 2'd0;
                end else begin
                    wcnt_nx = wcnt + 2'd1;
                end
            end
            S_ERR1: state_nx = S_ERR2;
            default: begin
                if (bus.HREADY) begin
                    if (!accept) begin
                        state_nx = S_IDLE;
                    end else if (!legal) begin
                        state_nx = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nx = S_WAIT;
                        wcnt_nx  = 2'd1;
                    end else begin
                        state_nx = S_DATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= S_IDLE;
            wcnt  <= 2'd0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    always_ff @(posedge HCLK) begin
        if (accept && !HRESET) begin
            addr_q <= bus.HADDR[AW-1:0];
            wr_q   <= bus.HWRITE;
            size_q <= bus.HSIZE;
        end
    end

    assign word_q = addr_q[AW-1:LB];
    assign commit = (state == S_DATA) && wr_q && bus.HREADY && !HRESET;

    always_comb begin
        int lane;
        int nbytes;
        be     = '0;
        lane   = int'(addr_q[LB-1:0]);
        nbytes = 1 << size_q;
        for (int i = 0; i < NB; i++) begin
            be[i] = (i >= lane) && (i < lane + nbytes);
        end
    end

    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[word_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
            end
        end
    end

    assign bus.HRDATA    = (state == S_DATA && !wr_q) ? mem[word_q] : '0;
    assign bus.HREADYOUT = !((state == S_WAIT) || (state == S_ERR1));
    assign bus.HRESP     = (state == S_ERR1) || (state == S_ERR2);
endmodule

// File: tb/tb_ahb3lite_sram_param.sv
// Randomised bench for ahb3lite_sram_param: three configurations checked
// cycle by cycle against a byte-addressed transaction model.
module tb_ahb3lite_sram_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        grst;
    int          cur_dut;
    logic        b_sel, b_wr, b_rst;
    logic [1:0]  b_trans;
    logic [31:0] b_addr;
    logic [2:0]  b_size;
    logic [63:0] b_wdata;

    ahb3lite_sram_param_if #(.DATA_WIDTH(32)) b0 ();
    ahb3lite_sram_param_if #(.DATA_WIDTH(32)) b1 ();
    ahb3lite_sram_param_if #(.DATA_WIDTH(64)) b2 ();

    logic r0, r1, r2;
    assign r0 = grst || (cur_dut == 0 && b_rst);
    assign r1 = grst || (cur_dut == 1 && b_rst);
    assign r2 = grst || (cur_dut == 2 && b_rst);

    assign b0.HSEL   = (cur_dut == 0) && b_sel;
    assign b0.HADDR  = b_addr;
    assign b0.HWRITE = b_wr;
    assign b0.HSIZE  = b_size;
    assign b0.HBURST = 3'd0;
    assign b0.HPROT  = 4'd3;
    assign b0.HTRANS = (cur_dut == 0) ? b_trans : 2'd0;
    assign b0.HWDATA = b_wdata[31:0];
    assign b0.HREADY = b0.HREADYOUT;

    assign b1.HSEL   = (cur_dut == 1) && b_sel;
    assign b1.HADDR  = b_addr;
    assign b1.HWRITE = b_wr;
    assign b1.HSIZE  = b_size;
    assign b1.HBURST = 3'd1;
    assign b1.HPROT  = 4'd3;
    assign b1.HTRANS = (cur_dut == 1) ? b_trans : 2'd0;
    assign b1.HWDATA = b_wdata[31:0];
    assign b1.HREADY = b1.HREADYOUT;

    assign b2.HSEL   = (cur_dut == 2) && b_sel;
    assign b2.HADDR  = b_addr;
    assign b2.HWRITE = b_wr;
    assign b2.HSIZE  = b_size;
    assign b2.HBURST = 3'd0;
    assign b2.HPROT  = 4'd3;
    assign b2.HTRANS = (cur_dut == 2) ? b_trans : 2'd0;
    assign b2.HWDATA = b_wdata;
    assign b2.HREADY = b2.HREADYOUT;

    ahb3lite_sram_param #(.DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0))
        u_d0 (.HCLK(clk), .HRESET(r0), .bus(b0));
    ahb3lite_sram_param #(.DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3))
        u_d1 (.HCLK(clk), .HRESET(r1), .bus(b1));
    ahb3lite_sram_param #(.DATA_WIDTH(64), .MEM_DEPTH(128), .WAIT_STATES(2))
        u_d2 (.HCLK(clk), .HRESET(r2), .bus(b2));

    logic        obs_rdy, obs_resp;
    logic [63:0] obs_rd;
    always_comb begin
        obs_rdy  = b0.HREADYOUT;
        obs_resp = b0.HRESP;
        obs_rd   = {32'd0, b0.HRDATA};
        if (cur_dut == 1) begin
            obs_rdy  = b1.HREADYOUT;
            obs_resp = b1.HRESP;
            obs_rd   = {32'd0, b1.HRDATA};
        end else if (cur_dut == 2) begin
            obs_rdy  = b2.HREADYOUT;
            obs_resp = b2.HRESP;
            obs_rd   = b2.HRDATA;
        end
    end

    // kind: 0 transfer/idle, 1 reset cycle, 2 stall cycle
    typedef struct packed {
        logic [1:0]  kind;
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic        chk;
        logic [63:0] exp;
    } stim_t;

    stim_t q[$];
    stim_t cur;

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0] ref_mem [3][1024];

    int          ph_kind;
    int          ph_left;
    logic [31:0] ph_addr;
    logic        ph_wr;
    logic [2:0]  ph_size;
    logic [63:0] ph_wdata;
    logic        ph_chk;
    logic [63:0] ph_exp;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int nb_of(int d);
        return (d == 2) ? 8 : 4;
    endfunction

    function automatic int lg_of(int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic int ws_of(int d);
        return (d == 0) ? 0 : (d == 1) ? 3 : 2;
    endfunction

    function automatic bit is_legal(int d, logic [31:0] a, logic [2:0] sz);
        bit ok;
        ok = (a < 32'd1024) && (int'(sz) <= lg_of(d));
        ok = ok && ((a & ((32'd1 << sz) - 32'd1)) == 32'd0);
        return ok;
    endfunction

    function automatic logic [63:0] ref_word(int d, logic [31:0] a);
        logic [63:0] r;
        int base;
        r    = 64'd0;
        base = int'(a) & ~(nb_of(d) - 1);
        for (int i = 0; i < nb_of(d); i++) r[8*i +: 8] = ref_mem[d][base + i];
        return r;
    endfunction

    function automatic stim_t idle_it();
        stim_t s;
        s       = '0;
        s.sel   = 1'b1;
        return s;
    endfunction

    function automatic stim_t xf(logic wr, logic [31:0] a, logic [2:0] sz,
                                 logic [63:0] wd);
        stim_t s;
        s       = idle_it();
        s.trans = 2'd2;
        s.wr    = wr;
        s.addr  = a;
        s.size  = sz;
        s.wdata = wd;
        return s;
    endfunction

    function automatic stim_t rd_chk(logic [31:0] a, logic [2:0] sz,
                                     logic [63:0] e);
        stim_t s;
        s     = xf(1'b0, a, sz, 64'd0);
        s.chk = 1'b1;
        s.exp = e;
        return s;
    endfunction

    function automatic stim_t rnd_it(int d);
        stim_t s;
        int r;
        int lg;
        lg = lg_of(d);
        s  = idle_it();
        r  = int'($urandom_range(0, 99));
        if (r < 3) begin
            s.kind = 2'd1;
            s.sel  = 1'b0;
        end else begin
            s.sel   = ($urandom_range(0, 19) != 0);
            r       = int'($urandom_range(0, 9));
            s.trans = (r < 6) ? 2'd2 : (r < 8) ? 2'd3 : (r < 9) ? 2'd0 : 2'd1;
            s.wr    = 1'($urandom_range(0, 1));
            s.size  = 3'($urandom_range(0, lg));
            s.addr  = $urandom_range(0, 1023) & ~((32'd1 << s.size) - 32'd1);
            r       = int'($urandom_range(0, 19));
            if (r == 0) s.addr = s.addr | (32'd1 << $urandom_range(10, 31));
            else if (r == 1) s.addr = s.addr | 32'd1;
            else if (r == 2) s.size = 3'($urandom_range(lg + 1, 7));
            s.wdata = {$urandom, $urandom};
        end
        return s;
    endfunction

    task automatic drive();
        b_sel   = (cur.kind == 2'd0) && cur.sel;
        b_trans = (cur.kind == 2'd0) ? cur.trans : 2'd0;
        b_wr    = cur.wr;
        b_addr  = cur.addr;
        b_size  = cur.size;
        b_rst   = (cur.kind == 2'd1);
        b_wdata = ph_wdata;
    endtask

    task automatic check_out(int d);
        bit fin;
        bit rd_fin;
        logic [63:0] er;
        fin    = (ph_kind == 0) || (ph_left == 1);
        rd_fin = (ph_kind == 1) && !ph_wr && (ph_left == 1);
        er     = rd_fin ? ref_word(d, ph_addr) : 64'd0;
        chk($sformatf("d%0d_hreadyout", d), {63'd0, obs_rdy}, {63'd0, fin});
        chk($sformatf("d%0d_hresp", d), {63'd0, obs_resp},
            {63'd0, ph_kind == 2});
        chk($sformatf("d%0d_hrdata", d), obs_rd, er);
        if (rd_fin && ph_chk) chk($sformatf("d%0d_directed", d), obs_rd, ph_exp);
    endtask

    task automatic step_model(int d, output bit taken);
        bit was_ready;
        int a;
        int nb;
        nb        = nb_of(d);
        was_ready = (ph_kind == 0) || (ph_left == 1);
        taken     = was_ready || (cur.kind != 2'd0);
        if (cur.kind == 2'd1) begin
            ph_kind = 0;
        end else if (!was_ready) begin
            ph_left--;
        end else begin
            if (ph_kind == 1 && ph_wr) begin
                for (int k = 0; k < (1 << ph_size); k++) begin
                    a = int'(ph_addr) + k;
                    ref_mem[d][a] = ph_wdata[8*(a % nb) +: 8];
                end
            end
            ph_kind = 0;
            if (cur.kind == 2'd0 && cur.sel && cur.trans[1]) begin
                ph_addr  = cur.addr;
                ph_wr    = cur.wr;
                ph_size  = cur.size;
                ph_wdata = cur.wdata;
                ph_chk   = cur.chk;
                ph_exp   = cur.exp;
                if (is_legal(d, cur.addr, cur.size)) begin
                    ph_kind = 1;
                    ph_left = ws_of(d) + 1;
                end else begin
                    ph_kind = 2;
                    ph_left = 2;
                end
            end
        end
    endtask

    task automatic run_dut(int d);
        bit taken;
        cur_dut = d;
        cur     = idle_it();
        ph_kind = 0;
        drive();
        do begin
            @(negedge clk);
            check_out(d);
            @(posedge clk);
            step_model(d, taken);
            #1;
            if (taken) begin
                if (q.size() > 0) cur = q.pop_front();
                else cur = idle_it();
            end
            drive();
        end while (q.size() > 0 || ph_kind != 0 || cur.kind != 2'd0 ||
                   (cur.sel && cur.trans[1]));
    endtask

    task automatic load_init(int d);
        int nb;
        nb = nb_of(d);
        for (int w = 0; w < 1024 / nb; w++)
            q.push_back(xf(1'b1, 32'(w * nb), 3'(lg_of(d)),
                           {$urandom, $urandom}));
    endtask

    task automatic load_rand(int d, int n);
        for (int i = 0; i < n; i++) q.push_back(rnd_it(d));
    endtask

    stim_t st_s, rs_s;

    initial begin
        grst     = 1'b1;
        cur_dut  = 0;
        cur      = idle_it();
        ph_kind  = 0;
        ph_left  = 0;
        ph_wdata = 64'd0;
        drive();
        st_s      = '0;
        st_s.kind = 2'd2;
        rs_s      = '0;
        rs_s.kind = 2'd1;
        repeat (2) @(posedge clk);
        #1 grst = 1'b0;
        @(negedge clk);
        chk("rst_rdy0", {63'd0, b0.HREADYOUT}, 64'd1);
        chk("rst_resp0", {63'd0, b0.HRESP}, 64'd0);
        chk("rst_rd0", {32'd0, b0.HRDATA}, 64'd0);
        chk("rst_rdy1", {63'd0, b1.HREADYOUT}, 64'd1);
        chk("rst_rdy2", {63'd0, b2.HREADYOUT}, 64'd1);
        chk("rst_rd2", b2.HRDATA, 64'd0);

        for (int i = 0; i < 5; i++) q.push_back(idle_it());
        load_init(0);
        q.push_back(xf(1'b1, 32'h10, 3'd2, 64'hDEADBEEF));
        q.push_back(rd_chk(32'h10, 3'd2, 64'hDEADBEEF));
        q.push_back(xf(1'b1, 32'h20, 3'd2, 64'h0));
        q.push_back(xf(1'b1, 32'h21, 3'd0, 64'h0000AA00));
        q.push_back(xf(1'b1, 32'h22, 3'd1, 64'h12340000));
        q.push_back(rd_chk(32'h20, 3'd2, 64'h1234AA00));
        q.push_back(xf(1'b1, 32'h400, 3'd2, 64'h99999999));
        q.push_back(xf(1'b0, 32'h000, 3'd2, 64'h0));
        q.push_back(xf(1'b1, 32'h02, 3'd2, 64'h77777777));
        q.push_back(xf(1'b0, 32'h00, 3'd3, 64'h0));
        q.push_back(xf(1'b1, 32'h8000_0010, 3'd2, 64'h66666666));
        q.push_back(rd_chk(32'h10, 3'd2, 64'hDEADBEEF));
        load_rand(0, 400);
        run_dut(0);

        load_init(1);
        q.push_back(xf(1'b1, 32'h08, 3'd2, 64'h11112222));
        q.push_back(rd_chk(32'h08, 3'd2, 64'h11112222));
        q.push_back(xf(1'b1, 32'h08, 3'd2, 64'h55));
        q.push_back(st_s);
        q.push_back(rs_s);
        q.push_back(rd_chk(32'h08, 3'd2, 64'h11112222));
        load_rand(1, 300);
        run_dut(1);

        load_init(2);
        q.push_back(xf(1'b1, 32'h18, 3'd3, 64'h0123456789ABCDEF));
        q.push_back(rd_chk(32'h18, 3'd3, 64'h0123456789ABCDEF));
        q.push_back(rd_chk(32'h1C, 3'd2, 64'h0123456789ABCDEF));
        q.push_back(xf(1'b1, 32'h04, 3'd3, 64'h0));
        q.push_back(xf(1'b0, 32'h00, 3'd4, 64'h0));
        load_rand(2, 300);
        run_dut(2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
